// File: rtl/ahb_lite_usb_mgr.sv
// AHB-Lite single-beat manager for the USB satellite: valid/ready commands in, in-order responses out.
// Optional data-phase watchdog with sticky bus_hung output is enabled by defining AHB_MGR_TIMEOUT_EN.
module ahb_lite_usb_mgr #(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic              hsel,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [ADDR_W-1:0] haddr,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp
`ifdef AHB_MGR_TIMEOUT_EN
  ,
  output logic              bus_hung
`endif
);

  // APH stage; haddr/hsize/hwrite live here and keep their value when the bus goes idle
  logic              aph_vld_q, aph_vld_d;
  logic              aph_loc_q, aph_loc_d;
  logic              aph_lwr_q, aph_lwr_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d;
  logic [31:0]       aph_wdata_q, aph_wdata_d;
  // DPH stage
  logic              dph_vld_q, dph_vld_d;
  logic              dph_write_q, dph_write_d;
  logic [31:0]       dph_wdata_q, dph_wdata_d;
  logic              err2_q, err2_d;
  // response register
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic [31:0]       rsp_rd_q, rsp_rd_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_loc_q, rsp_loc_d;

  logic bus_adv, loc_ret, dph_done, acc, acc_loc, direct;
  logic to_fire, hung;

`ifdef AHB_MGR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             hung_q, hung_d;

  always_comb begin
    to_fire  = dph_vld_q && !hready && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    to_cnt_d = (dph_vld_q && !hready && !to_fire) ? to_cnt_q + 1'b1 : '0;
    hung_d   = hung_q || to_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      hung_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      hung_q   <= hung_d;
    end
  end

  assign hung     = hung_q;
  assign bus_hung = hung_q;
`else
  logic unused_timeout;
  assign to_fire        = 1'b0;
  assign hung           = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    bus_adv   = aph_vld_q && !aph_loc_q && !err2_q && hready && !hresp;
    // a reserved-size entry may only retire once nothing older is still on the bus
    loc_ret   = aph_vld_q && aph_loc_q && !dph_vld_q;
    dph_done  = dph_vld_q && hready;
    cmd_ready = !rst && !hung && (!aph_vld_q || bus_adv || loc_ret);
    acc       = cmd_valid && cmd_ready;
    acc_loc   = acc && (cmd_size == 2'd3);
    direct    = acc_loc && !aph_vld_q && !dph_vld_q;

    aph_vld_d   = aph_vld_q && !bus_adv && !loc_ret;
    aph_loc_d   = aph_loc_q;
    aph_lwr_d   = aph_lwr_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    aph_wdata_d = aph_wdata_q;
    if (acc && !acc_loc) begin
      aph_vld_d   = 1'b1;
      aph_loc_d   = 1'b0;
      haddr_d     = cmd_addr;
      hsize_d     = cmd_size;
      hwrite_d    = cmd_write;
      aph_wdata_d = cmd_wdata;
    end else if (acc_loc && !direct) begin
      aph_vld_d = 1'b1;
      aph_loc_d = 1'b1;
      aph_lwr_d = cmd_write;
    end

    dph_vld_d   = dph_vld_q && !dph_done && !to_fire;
    dph_write_d = dph_write_q;
    dph_wdata_d = dph_wdata_q;
    if (bus_adv) begin
      dph_vld_d   = 1'b1;
      dph_write_d = hwrite_q;
      dph_wdata_d = aph_wdata_q;
    end

    err2_d = err2_q;
    if (dph_done || to_fire)                err2_d = 1'b0;
    else if (dph_vld_q && hresp && !hready) err2_d = 1'b1;

    // these four sources are mutually exclusive on any one edge
    rsp_vld_d = 1'b0;
    rsp_wr_d  = 1'b0;
    rsp_rd_d  = '0;
    rsp_err_d = 1'b0;
    rsp_loc_d = 1'b0;
    if (dph_done) begin
      rsp_vld_d = 1'b1;
      rsp_wr_d  = dph_write_q;
      rsp_rd_d  = dph_write_q ? '0 : hrdata;
      rsp_err_d = hresp;
    end else if (to_fire) begin
      rsp_vld_d = 1'b1;
      rsp_wr_d  = dph_write_q;
      rsp_err_d = 1'b1;
    end else if (loc_ret) begin
      rsp_vld_d = 1'b1;
      rsp_wr_d  = aph_lwr_q;
      rsp_err_d = 1'b1;
      rsp_loc_d = 1'b1;
    end else if (direct) begin
      rsp_vld_d = 1'b1;
      rsp_wr_d  = cmd_write;
      rsp_err_d = 1'b1;
      rsp_loc_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aph_vld_q   <= 1'b0;
      aph_loc_q   <= 1'b0;
      aph_lwr_q   <= 1'b0;
      haddr_q     <= '0;
      hsize_q     <= '0;
      hwrite_q    <= 1'b0;
      aph_wdata_q <= '0;
      dph_vld_q   <= 1'b0;
      dph_write_q <= 1'b0;
      dph_wdata_q <= '0;
      err2_q      <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_loc_q   <= 1'b0;
    end else begin
      aph_vld_q   <= aph_vld_d;
      aph_loc_q   <= aph_loc_d;
      aph_lwr_q   <= aph_lwr_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      aph_wdata_q <= aph_wdata_d;
      dph_vld_q   <= dph_vld_d;
      dph_write_q <= dph_write_d;
      dph_wdata_q <= dph_wdata_d;
      err2_q      <= err2_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
      rsp_loc_q   <= rsp_loc_d;
    end
  end

  assign hsel      = aph_vld_q && !aph_loc_q && !err2_q;
  assign htrans    = hsel ? 2'b10 : 2'b00;
  assign haddr     = haddr_q;
  assign hsize     = {1'b0, hsize_q};
  assign hwrite    = hwrite_q;
  assign hburst    = 3'b000;
  assign hwdata    = (dph_vld_q && dph_write_q) ? dph_wdata_q : '0;
  assign rsp_valid = rsp_vld_q;
  assign rsp_write = rsp_wr_q;
  assign rsp_rdata = rsp_rd_q;
  assign rsp_error = rsp_err_q;
  assign busy      = aph_vld_q || dph_vld_q || err2_q || (rsp_vld_q && rsp_loc_q);

endmodule

// File: tb/tb_ahb_lite_usb_mgr.sv
// Scoreboard bench for ahb_lite_usb_mgr: behavioural slave with random waits/errors, in-order model.
module tb_ahb_lite_usb_mgr;
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [1:0] cmd_size;
  logic [31:0] cmd_wdata;
  logic rsp_valid, rsp_write, rsp_error, busy, hsel, hwrite, hready, hresp;
  logic [31:0] rsp_rdata, hwdata, hrdata;
  logic [1:0] htrans;
  logic [3:0] haddr;
  logic [2:0] hsize, hburst;
`ifdef AHB_MGR_TIMEOUT_EN
  logic bus_hung;
`endif

  always #5 clk = ~clk;

  ahb_lite_usb_mgr #(.ADDR_W(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy), .hsel(hsel), .hwrite(hwrite), .htrans(htrans), .haddr(haddr), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
`ifdef AHB_MGR_TIMEOUT_EN
    , .bus_hung(bus_hung)
`endif
  );

  typedef struct { logic w; logic [31:0] rd; logic err; } exp_t;
  typedef struct { logic [3:0] a; int acyc; logic [31:0] wd; int dcyc; } log_t;
  exp_t q[$];
  log_t slog[$];
  int errors = 0, checks = 0;
  int force_wait = -1;
  int bus_xfers = 0, exp_xfers = 0;
  logic [31:0] smem [16];
  logic [31:0] mmem [16];

  // snapshots taken mid-cycle, consumed by the slave just after the next edge
  logic sn_rst = 1'b1, sn_hsel = 1'b0, sn_hwrite = 1'b0, sn_hready = 1'b1;
  logic [1:0] sn_htrans = 2'b00;
  logic [3:0] sn_haddr = '0;
  logic [31:0] sn_hwdata = '0;
  logic p_rst = 1'b1, p_ns = 1'b0, p_rdy = 1'b1, p_resp = 1'b0, p_w = 1'b0;
  logic [3:0] p_addr = '0;
  logic [2:0] p_size = '0;
  logic [31:0] p_wd = '0;
  exp_t mon_e;

  // slave: errors on addresses 0xE/0xF, random or forced wait states otherwise
  initial begin
    bit s_dp, s_w, s_err;
    logic [3:0] s_a;
    int s_wait, s_est, s_acyc, scyc;
    s_dp = 0; s_w = 0; s_err = 0; s_a = 0; s_wait = 0; s_est = 0; s_acyc = 0; scyc = 0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    forever begin
      @(posedge clk);
      #1;
      scyc++;
      if (sn_rst) begin
        s_dp = 0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
      end else begin
        if (s_dp && sn_hready) begin
          if (s_w && !s_err) smem[s_a] = sn_hwdata;
          slog.push_back('{s_a, s_acyc, sn_hwdata, scyc});
          s_dp = 0;
        end
        if (sn_hsel && sn_htrans == 2'b10 && sn_hready) begin
          s_dp = 1; s_a = sn_haddr; s_w = sn_hwrite; s_err = (sn_haddr >= 4'hE);
          s_est = 0; s_acyc = scyc; bus_xfers++;
          s_wait = (force_wait >= 0) ? force_wait :
                   (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        if (!s_dp) begin
          hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
        end else if (s_err) begin
          hrdata = '0; hresp = 1'b1;
          hready = (s_est != 0);
          s_est = 1;
        end else if (s_wait > 0) begin
          hready = 1'b0; hresp = 1'b0; hrdata = $urandom; s_wait--;
        end else begin
          hready = 1'b1; hresp = 1'b0; hrdata = s_w ? $urandom : smem[s_a];
        end
      end
    end
  end

  // monitor: scoreboard pops plus bus-protocol checks
  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got w=%0b rd=%h err=%0b with nothing outstanding", rsp_write, rsp_rdata, rsp_error);
      end else begin
        mon_e = q.pop_front();
        if (rsp_write !== mon_e.w || rsp_rdata !== mon_e.rd || rsp_error !== mon_e.err) begin
          errors++;
          $display("FAIL rsp: got w=%0b rd=%h err=%0b expected w=%0b rd=%h err=%0b",
                   rsp_write, rsp_rdata, rsp_error, mon_e.w, mon_e.rd, mon_e.err);
        end
      end
    end
    if (hready && hresp) begin
      checks++;
      if (hsel || htrans != 2'b00) begin
        errors++;
        $display("FAIL err2_idle: hsel=%0b htrans=%0d expected 0/IDLE", hsel, htrans);
      end
    end
    if (!rst && !p_rst && p_ns && !p_rdy && !p_resp) begin
      checks++;
      if (!(hsel && htrans == 2'b10 && haddr == p_addr && hwrite == p_w && hsize == p_size && hwdata == p_wd && hburst == 3'b000)) begin
        errors++;
        $display("FAIL wait_hold: addr=%h w=%0b size=%0d wd=%h expected addr=%h w=%0b size=%0d wd=%h",
                 haddr, hwrite, hsize, hwdata, p_addr, p_w, p_size, p_wd);
      end
    end
    p_rst = rst; p_ns = hsel && htrans == 2'b10; p_rdy = hready; p_resp = hresp;
    p_addr = haddr; p_w = hwrite; p_size = hsize; p_wd = hwdata;
    sn_rst = rst; sn_hsel = hsel; sn_htrans = htrans; sn_haddr = haddr;
    sn_hwrite = hwrite; sn_hwdata = hwdata; sn_hready = hready;
  end

  // offer a command; the expected response is derived from the command order alone
  task automatic send(input bit w, input logic [3:0] a, input logic [1:0] s, input logic [31:0] d,
                      input bit hang, output int t);
    exp_t e;
    bit ok = 0;
    t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    while (!ok && t < 300) begin
      @(negedge clk);
      t++;
      if (cmd_ready) ok = 1;
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", t);
    end else begin
      e.w = w; e.rd = '0; e.err = 1'b0;
      if (s == 2'd3 || hang || a >= 4'hE) e.err = 1'b1;
      else if (w) mmem[a] = d;
      else e.rd = mmem[a];
      q.push_back(e);
      if (s != 2'd3) exp_xfers++;
    end
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((busy || q.size() != 0) && t < 500);
    if (t >= 500) begin
      errors++; checks++;
      $display("FAIL idle_timeout: busy=%0b outstanding=%0d expected 0/0", busy, q.size());
    end
    @(posedge clk);
    #2;
  endtask

  task automatic lat(input bit w, input logic [3:0] a, input logic [1:0] s, input logic [31:0] d,
                     input bit hang, input int exp_n, input string nm);
    int n = 0;
    int t;
    wait_idle();
    send(w, a, s, d, hang, t);
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 200);
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL %s: latency=%0d expected %0d", nm, n, exp_n);
    end
  endtask

  task automatic chk_zero(input string nm);
    logic [82:0] v;
    v = {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, busy, hsel, hwrite,
         htrans, haddr, hsize, hburst, hwdata};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h expected 0", nm, v);
    end
  endtask

  initial begin
    int t1, t2, x0, n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      smem[i] = 32'h0101_0101 * i;
      mmem[i] = 32'h0101_0101 * i;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_state");
    @(posedge clk);
    #2 rst = 1'b0;

    // single write then read-back, zero wait states
    force_wait = 0;
    lat(1'b1, 4'hC, 2'd1, 32'h1, 1'b0, 3, "t1_write_lat");
    lat(1'b0, 4'hC, 2'd1, 32'h0, 1'b0, 3, "t1_read_lat");

    // back-to-back writes overlap address and data phases
    wait_idle();
    send(1'b1, 4'hC, 2'd2, 32'hF, 1'b0, t1);
    send(1'b1, 4'hD, 2'd2, 32'h1, 1'b0, t2);
    checks++;
    if (t1 != 1 || t2 != 1) begin
      errors++;
      $display("FAIL t2_ready: accept waits=%0d,%0d expected 1,1", t1, t2);
    end
    wait_idle();
    n = slog.size();
    checks++;
    if (n < 2 || slog[n-2].a != 4'hC || slog[n-1].a != 4'hD || slog[n-1].acyc != slog[n-2].acyc + 1 ||
        slog[n-2].dcyc != slog[n-2].acyc + 1 || slog[n-2].wd != 32'hF || slog[n-1].wd != 32'h1) begin
      errors++;
      $display("FAIL t2_pipeline: entries=%0d last addrs=%h,%h wd=%h,%h expected C,D with wd F,1 on consecutive cycles",
               n, slog[n-2].a, slog[n-1].a, slog[n-2].wd, slog[n-1].wd);
    end

    // error response with a queued read behind it
    send(1'b0, 4'hF, 2'd2, 32'h0, 1'b0, t1);
    send(1'b0, 4'hC, 2'd2, 32'h0, 1'b0, t1);
    wait_idle();

    // wait states stall the pipeline
    force_wait = 5;
    lat(1'b1, 4'h5, 2'd2, 32'hA5A5_0001, 1'b0, 8, "t4_wait_lat");
    wait_idle();
    send(1'b1, 4'h6, 2'd2, 32'h1234_5678, 1'b0, t1);
    send(1'b0, 4'h6, 2'd2, 32'h0, 1'b0, t1);
    send(1'b0, 4'h5, 2'd2, 32'h0, 1'b0, t2);
    checks++;
    if (t2 != 6) begin
      errors++;
      $display("FAIL t4_ready_held: accept waits=%0d expected 6", t2);
    end
    wait_idle();

    // reserved size between two reads: local error response, no bus transfer
    force_wait = 0;
    x0 = bus_xfers;
    send(1'b0, 4'h1, 2'd2, 32'h0, 1'b0, t1);
    send(1'b0, 4'h2, 2'd3, 32'h0, 1'b0, t1);
    send(1'b0, 4'h3, 2'd2, 32'h0, 1'b0, t1);
    wait_idle();
    checks++;
    if (bus_xfers - x0 != 2) begin
      errors++;
      $display("FAIL t5_xfers: bus transfers=%0d expected 2", bus_xfers - x0);
    end
    lat(1'b1, 4'h4, 2'd3, 32'h0, 1'b0, 1, "t5_local_lat");

    // reset in the middle of a data phase drops the transfer
    wait_idle();
    force_wait = 20;
    send(1'b0, 4'h3, 2'd2, 32'h0, 1'b0, t1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 q.delete();
    @(negedge clk);
    chk_zero("t6_reset_mid_dph");
    @(posedge clk);
    #2 rst = 1'b0;
    force_wait = -1;
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [1:0] s;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2;
      end
      s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), s, $urandom, 1'b0, t1);
    end
    wait_idle();

`ifdef AHB_MGR_TIMEOUT_EN
    force_wait = 1000;
    lat(1'b1, 4'h2, 2'd2, 32'hDEAD_BEEF, 1'b1, 66, "t6_timeout_lat");
    @(negedge clk);
    checks++;
    if (!(bus_hung && !cmd_ready)) begin
      errors++;
      $display("FAIL t6_hung: bus_hung=%0b cmd_ready=%0b expected 1/0", bus_hung, cmd_ready);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    force_wait = -1;
    wait_idle();
`endif

    checks++;
    if (bus_xfers != exp_xfers || q.size() != 0) begin
      errors++;
      $display("FAIL final: bus transfers=%0d outstanding=%0d expected %0d/0", bus_xfers, q.size(), exp_xfers);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
